// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forward-select codes, pipeline tag layout
// and the writer predicate used by the forwarding logic.
package cpu_pkg;

  // Width of the rd field stored in a pipeline tag (register-index width).
  localparam int TAG_RD_W = 5;

  // Forward-select codes driven to the EX-stage operand muxes.
  localparam logic [1:0] FW_REG = 2'b00;  // register-file data
  localparam logic [1:0] FW_WB  = 2'b01;  // MEM/WB write-back result
  localparam logic [1:0] FW_EX  = 2'b10;  // EX/MEM ALU result

  // Destination tag carried alongside an instruction through the pipeline.
  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } pipe_tag_t;

  // Tag of an injected bubble: nothing valid, nothing written.
  localparam pipe_tag_t BUBBLE_TAG = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

  // A tag is a forwarding source only if it is a real instruction that writes
  // a register other than $0 ($0 is hardwired to zero).
  function automatic logic is_writer(input pipe_tag_t tag);
    return tag.valid && tag.regwrite && (tag.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Forward-select resolver for one EX operand. Looks at the tag that will sit
// in EX/MEM and the tag that will sit in MEM/WB after the next edge and picks
// the youngest producer of the source register.
module fwd_match
  import cpu_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  pipe_tag_t        ex_tag_i,
  input  pipe_tag_t        mem_tag_i,
  output logic [1:0]       sel_o
);

  logic ex_hit;
  logic mem_hit;

  // A stage hits when it is a genuine writer of the register this operand reads.
  always_comb begin
    ex_hit  = use_i && is_writer(ex_tag_i)  && (ex_tag_i.rd  == src_i);
    mem_hit = use_i && is_writer(mem_tag_i) && (mem_tag_i.rd == src_i);
  end

  // The younger producer (EX/MEM) wins over the older one (MEM/WB); 11 never appears.
  always_comb begin
    sel_o = FW_REG;
    if (ex_hit) begin
      sel_o = FW_EX;
    end else if (mem_hit) begin
      sel_o = FW_WB;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps destination tags for ID/EX and EX/MEM, registers the EX-stage operand
// forward selects one cycle ahead, and raises a combinational load-use stall.
//
// The MEM/WB tag is not kept: the register file is write-before-read, so an
// instruction leaving MEM/WB never needs forwarding to the instruction that
// is in ID at that moment, and the forward selects are computed from the
// tags as they will be after the edge (T_EX -> EX/MEM, T_MEM -> MEM/WB).
module forward_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic [1:0]       fw_a_o,
  output logic [1:0]       fw_b_o,
  output logic             stall_o
);

  pipe_tag_t  t_ex_reg;
  pipe_tag_t  t_mem_reg;
  pipe_tag_t  t_ex_next;
  pipe_tag_t  id_tag;
  logic [1:0] fw_a_reg;
  logic [1:0] fw_b_reg;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_use;
  logic       insert_bubble;

  // Pack the ID-stage instruction into a tag as it would enter ID/EX.
  always_comb begin
    id_tag          = BUBBLE_TAG;
    id_tag.valid    = 1'b1;
    id_tag.rd       = id_rd_i;
    id_tag.regwrite = id_regwrite_i;
    id_tag.memread  = id_memread_i;
  end

  // Load-use: the load in EX cannot forward in time to the reader in ID.
  // A frozen pipeline never stalls, since nothing would advance anyway.
  always_comb begin
    load_use = is_writer(t_ex_reg) && t_ex_reg.memread &&
               ((id_use_rs_i && (id_rs_i == t_ex_reg.rd)) ||
                (id_use_rt_i && (id_rt_i == t_ex_reg.rd)));
    stall_o  = load_use && !hold_i;
  end

  // A stall and a flush both squash the ID slot; together they still give one bubble.
  always_comb begin
    insert_bubble = stall_o || flush_i;
    t_ex_next     = insert_bubble ? BUBBLE_TAG : id_tag;
  end

  fwd_match #(
    .REG_W(REG_W)
  ) u_match_a (
    .src_i    (id_rs_i),
    .use_i    (id_use_rs_i),
    .ex_tag_i (t_ex_reg),
    .mem_tag_i(t_mem_reg),
    .sel_o    (sel_a)
  );

  fwd_match #(
    .REG_W(REG_W)
  ) u_match_b (
    .src_i    (id_rt_i),
    .use_i    (id_use_rt_i),
    .ex_tag_i (t_ex_reg),
    .mem_tag_i(t_mem_reg),
    .sel_o    (sel_b)
  );

  // Advance tag registers and forward selects together with the ID/EX register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t_ex_reg  <= BUBBLE_TAG;
      t_mem_reg <= BUBBLE_TAG;
      fw_a_reg  <= FW_REG;
      fw_b_reg  <= FW_REG;
    end else if (!hold_i) begin
      t_mem_reg <= t_ex_reg;
      t_ex_reg  <= t_ex_next;
      fw_a_reg  <= insert_bubble ? FW_REG : sel_a;
      fw_b_reg  <= insert_bubble ? FW_REG : sel_b;
    end
  end

  assign fw_a_o = fw_a_reg;
  assign fw_b_o = fw_b_reg;

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed hazard scenarios followed by
// randomized traffic, compared against an instruction-history model.
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] id_rs_i = '0;
  logic [4:0] id_rt_i = '0;
  logic [4:0] id_rd_i = '0;
  logic       id_use_rs_i = 1'b0;
  logic       id_use_rt_i = 1'b0;
  logic       id_regwrite_i = 1'b0;
  logic       id_memread_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       hold_i = 1'b0;
  logic [1:0] fw_a_o;
  logic [1:0] fw_b_o;
  logic       stall_o;

  always #5 clk = ~clk;

  forward_ctrl #(.REG_W(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_rd_i      (id_rd_i),
    .id_use_rs_i  (id_use_rs_i),
    .id_use_rt_i  (id_use_rt_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i (id_memread_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .fw_a_o       (fw_a_o),
    .fw_b_o       (fw_b_o),
    .stall_o      (stall_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the instructions that have left ID, youngest first.
  // hist[0] is in EX now, hist[1] in MEM, hist[2] in WB.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t hist[3];
  int   exp_fa = 0;
  int   exp_fb = 0;
  bit   known  = 1'b0;

  function automatic bit produces(ins_t i, int r);
    return i.v && i.rw && (i.rd != 0) && (i.rd == r);
  endfunction

  // Youngest in-flight producer still ahead of the register file supplies the operand.
  function automatic int model_sel(bit used, int r);
    if (!used) return 0;
    if (produces(hist[0], r)) return 2;  // will be in EX/MEM
    if (produces(hist[1], r)) return 1;  // will be in MEM/WB
    return 0;                            // WB writes before read: register file
  endfunction

  function automatic bit model_stall();
    if (hold_i) return 1'b0;
    return hist[0].mr && ((id_use_rs_i && produces(hist[0], int'(id_rs_i))) ||
                          (id_use_rt_i && produces(hist[0], int'(id_rt_i))));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive ID inputs, check the stall, clock, check forwards.
  task automatic step(input logic r, input logic h, input logic f,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic urs, input logic urt, input logic rw, input logic mr);
    bit   st;
    ins_t nxt;
    rst_i = r; hold_i = h; flush_i = f;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_use_rs_i = urs; id_use_rt_i = urt;
    id_regwrite_i = rw; id_memread_i = mr;
    #1;
    st = model_stall();
    if (known) chk("stall", {31'b0, stall_o}, {31'b0, st});
    if (r) begin
      for (int i = 0; i < 3; i++) hist[i] = '{v: 0, rd: 0, rw: 0, mr: 0};
      exp_fa = 0; exp_fb = 0; known = 1'b1;
    end else if (!h && known) begin
      if (st || f) begin
        exp_fa = 0; exp_fb = 0;
        nxt = '{v: 0, rd: 0, rw: 0, mr: 0};
      end else begin
        exp_fa = model_sel(urs, int'(rs));
        exp_fb = model_sel(urt, int'(rt));
        nxt = '{v: 1, rd: int'(rd), rw: rw, mr: mr};
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nxt;
    end
    @(posedge clk);
    #1;
    if (known) begin
      chk("fw_a", {30'b0, fw_a_o}, exp_fa);
      chk("fw_b", {30'b0, fw_b_o}, exp_fb);
    end
    $display("step rst=%0b hold=%0b flush=%0b rs=%0d rt=%0d rd=%0d use=%0b%0b rw=%0b mr=%0b -> stall=%0b fw_a=%0d fw_b=%0d",
             r, h, f, rs, rt, rd, urs, urt, rw, mr, st, fw_a_o, fw_b_o);
    @(negedge clk);
  endtask

  task automatic nop();
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);

    // Reset for two cycles with random ID inputs.
    step(1, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    step(1, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    nop();

    // EX/MEM forward, then MEM/WB forward across a one-instruction gap.
    step(0, 0, 0, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0);  // add $3
    step(0, 0, 0, 5'd3, 5'd4, 5'd6, 1, 1, 1, 0);  // sub rs=$3 -> 10
    step(0, 0, 0, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0);  // add $3
    nop();
    step(0, 0, 0, 5'd3, 5'd4, 5'd8, 1, 1, 1, 0);  // sub rs=$3 -> 01

    // Priority: two writes of $5, reader in rt.
    step(0, 0, 0, 5'd1, 5'd2, 5'd5, 1, 1, 1, 0);
    step(0, 0, 0, 5'd2, 5'd1, 5'd5, 1, 1, 1, 0);
    step(0, 0, 0, 5'd9, 5'd5, 5'd10, 1, 1, 1, 0); // -> fw_b 10

    // Load-use: one stall, then forward from MEM/WB.
    step(0, 0, 0, 5'd1, 5'd0, 5'd7, 1, 0, 1, 1);  // lw $7
    step(0, 0, 0, 5'd7, 5'd2, 5'd11, 1, 1, 1, 0); // add rs=$7 -> stall
    step(0, 0, 0, 5'd7, 5'd2, 5'd11, 1, 1, 1, 0); // retry -> fw_a 01
    nop();

    // $0 is never a forwarding source.
    step(0, 0, 0, 5'd1, 5'd2, 5'd0, 1, 1, 1, 0);
    step(0, 0, 0, 5'd0, 5'd0, 5'd12, 1, 1, 1, 0);

    // Load then non-reader of rt: no stall, no forward.
    step(0, 0, 0, 5'd1, 5'd0, 5'd7, 1, 0, 1, 1);
    step(0, 0, 0, 5'd2, 5'd7, 5'd13, 1, 0, 1, 0);
    nop();

    // Hold for three cycles with a pending load-use in ID.
    step(0, 0, 0, 5'd1, 5'd0, 5'd7, 1, 0, 1, 1);  // lw $7
    for (int i = 0; i < 3; i++) step(0, 1, 0, 5'd7, 5'd7, 5'd14, 1, 1, 1, 0);
    step(0, 0, 0, 5'd7, 5'd7, 5'd14, 1, 1, 1, 0); // stall
    step(0, 0, 0, 5'd7, 5'd7, 5'd14, 1, 1, 1, 0); // fw 01/01
    nop();

    // Flush together with a load-use: single bubble.
    step(0, 0, 0, 5'd1, 5'd0, 5'd7, 1, 0, 1, 1);
    step(0, 0, 1, 5'd7, 5'd3, 5'd15, 1, 1, 1, 0);
    step(0, 0, 0, 5'd7, 5'd7, 5'd16, 1, 1, 0, 0);

    // Randomized traffic on a small register range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Pipeline forwarding and load-use hazard controller for the 5-stage CPU. Tracks destination-register tags of the instructions in ID/EX, EX/MEM and MEM/WB, and produces the registered 2-bit forward selects that drive the EX-stage operand forwarding muxes (A and B). It also raises a combinational load-use stall for the ID stage. It is the producer side of the forward-select interface: 00 = register-file data, 01 = MEM/WB write-back result, 10 = EX/MEM ALU result.

## Interface
Parameters:
- REG_W, 5, register-index width
- (none other)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  pipeline clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- id_rs_i  in  REG_W  rs index of instruction in ID
- id_rt_i  in  REG_W  rt index of instruction in ID
- id_rd_i  in  REG_W  final destination index of ID instruction (after RegDst select)
- id_use_rs_i  in  1  ID instruction reads rs
- id_use_rt_i  in  1  ID instruction reads rt
- id_regwrite_i  in  1  ID instruction writes a register
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  squash ID instruction (branch taken); inject bubble into ID/EX
- hold_i  in  1  global freeze (memory wait); no tracking register advances
- fw_a_o  out  2  forward select for EX operand A (rs)
- fw_b_o  out  2  forward select for EX operand B (rt)
- stall_o  out  1  load-use stall: hold PC and IF/ID, bubble into ID/EX

## Operation
- Three tag registers, each {valid, rd, regwrite, memread}: T_EX (ID/EX), T_MEM (EX/MEM), T_WB (MEM/WB).
- Writer W counts for forwarding only if valid && regwrite && rd != 0.
- stall_o (combinational) = T_EX counts as writer && T_EX.memread && ((id_use_rs_i && id_rs_i == T_EX.rd) || (id_use_rt_i && id_rt_i == T_EX.rd)). Forced to 0 while hold_i is 1.
- Per edge with hold_i = 0:
  - T_WB <= T_MEM; T_MEM <= T_EX.
  - T_EX <= bubble (valid = 0) if stall_o || flush_i, else the ID tag.
  - fw_a_o <= 00 if bubble inserted. Otherwise 10 if rs used and T_EX (next EX/MEM) is a writer with rd == id_rs_i. Otherwise 01 if T_MEM (next MEM/WB) is a writer with rd == id_rs_i. Otherwise 00.
  - fw_b_o follows the same rule using id_rt_i and id_use_rt_i.
- Priority: EX/MEM (10) beats MEM/WB (01) when both match.
- Code 11 is never produced.
- hold_i = 1: all tag registers and fw outputs keep their values; stall_o = 0.
- Register file is write-before-read. A WB-stage write matching an ID read needs no forward.

## Timing
- Reset (rst_i high at edge): all tags valid = 0; fw_a_o = fw_b_o = 00; stall_o = 0 (follows from T_EX invalid).
- Reset dominates hold_i and flush_i.
- fw_a_o/fw_b_o: registered. They apply to the instruction in EX during the cycle after it left ID (1-cycle latency, aligned with the ID/EX register).
- stall_o: combinational, same cycle as ID inputs. Exactly one bubble per load-use. The following cycle yields fw = 01 for the loaded register.
- flush_i and stall_o together: single bubble; no double effect.
- rd == 0 with regwrite: never forwarded and never stalls.

## Structure
- Shared package cpu_pkg:
  - constants FW_REG = 2'b00, FW_WB = 2'b01, FW_EX = 2'b10
  - pipe_tag_t struct {valid, rd, regwrite, memread}
  - BUBBLE_TAG constant
- One sub-module is natural: fwd_match. Combinational; takes a source index, a use flag and two tags, and returns the 2-bit select. Instantiated twice (A, B).
- Tag registers and stall logic stay in forward_ctrl.

## Test plan
- Reset: assert rst_i 2 cycles with random inputs -> fw_a_o = fw_b_o = 00, stall_o = 0 on the first cycle after reset.
- EX/EX: add $3 in ID, then sub using rs = $3 -> fw_a_o = 10 in sub's EX cycle. Repeat with a one-instruction gap -> fw_a_o = 01.
- Priority: two consecutive writes to $5, then a reader of $5 in rt -> fw_b_o = 10, not 01.
- Load-use: lw $7, then add rs = $7 -> stall_o = 1 for exactly 1 cycle; T_EX bubble; add's EX cycle has fw_a_o = 01.
- $0 and non-reads: write $0 then read $0 -> 00, no stall. lw $7 then an instruction with id_use_rt_i = 0 and rt = $7 -> no stall, fw_b_o = 00.
- hold/flush: assert hold_i 3 cycles mid-sequence -> outputs frozen, stall_o = 0, correct forwarding resumes afterwards. flush_i with a pending load-use -> one bubble, fw = 00 next cycle.
